// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: display scan-out reads have priority over the pixel
// writer; a starvation counter forces a writer slot after repeated denials.
module fb_mem_arbiter #(
    parameter int w_addr        = 17,
    parameter int w_data        = 16,
    parameter int max_wr_starve = 4,
    parameter int rd_latency    = 1,
    parameter int w_miss        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [w_addr-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [w_data-1:0] disp_rdata,
    input  logic              wr_valid,
    input  logic [w_addr-1:0] wr_addr,
    input  logic [w_data-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [w_addr-1:0] mem_addr,
    output logic [w_data-1:0] mem_wdata,
    input  logic [w_data-1:0] mem_rdata,
    input  logic              clear_stats,
    output logic [w_miss-1:0] miss_count
);

    typedef enum logic {
        DISP_PRIO = 1'b0,
        WR_FORCE  = 1'b1
    } state_t;

    localparam logic [7:0]        starve_lim = 8'(max_wr_starve - 1);
    localparam logic [w_miss-1:0] miss_max   = {w_miss{1'b1}};
    localparam logic [w_miss-1:0] miss_one   = {{(w_miss-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [7:0]            starve_cnt;
    logic [7:0]            starve_next;
    logic                  wr_acc;
    logic [1:0]            rst_sync;
    logic                  arst_n;
    logic [rd_latency-1:0] rd_pipe;

    // Reset asserts immediately but releases only on a clock edge, two flops later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign arst_n = rst_sync[1];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= DISP_PRIO;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next  = DISP_PRIO;
        starve_next = starve_cnt;
        disp_gnt    = 1'b0;
        wr_ready    = 1'b0;
        wr_acc      = 1'b0;

        case (state)
            DISP_PRIO: begin
                disp_gnt = disp_req;
                wr_ready = ~disp_req;
            end
            WR_FORCE: begin
                wr_ready = 1'b1;
            end
            default: begin
                disp_gnt = disp_req;
                wr_ready = ~disp_req;
            end
        endcase

        wr_acc = wr_valid & wr_ready;

        // Only a pending writer that loses to the display accumulates starvation.
        if (wr_acc || !wr_valid) begin
            starve_next = 8'd0;
        end else if (state == DISP_PRIO && disp_req) begin
            if (starve_cnt == starve_lim) begin
                starve_next = 8'd0;
                state_next  = WR_FORCE;
            end else begin
                starve_next = starve_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (disp_gnt) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= disp_addr;
        end else if (wr_acc) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // rd_pipe[0] marks the command cycle; the last stage lines up with valid RAM data.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_pipe     <= '0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            rd_pipe[0] <= disp_gnt;
            for (int i = 1; i < rd_latency; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            disp_rvalid <= rd_pipe[rd_latency-1];
            if (rd_pipe[rd_latency-1]) begin
                disp_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            miss_count <= '0;
        end else if (clear_stats) begin
            miss_count <= '0;
        end else if (disp_req && !disp_gnt && miss_count != miss_max) begin
            miss_count <= miss_count + miss_one;
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: two instances (rd_latency 1 and 3, w_miss 16 and 4)
// share stimulus; read data is checked through per-instance expectation queues.
module tb_fb_mem_arbiter;

    localparam int lat1 = 3;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        wr_valid = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clear_stats = 1'b0;

    logic        disp_gnt [2];
    logic        disp_rvalid [2];
    logic [15:0] disp_rdata [2];
    logic        wr_ready [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [16:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata0 = '0;
    logic [15:0] mem_rdata1 = '0;
    logic [15:0] miss0;
    logic [3:0]  miss1;

    logic [15:0] ram0 [int];
    logic [15:0] ram1 [int];
    logic [15:0] shadow [int];
    logic [15:0] stage1 [lat1-1];
    exp_t        q0 [$];
    exp_t        q1 [$];

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        exp_en = 1'b0;
    logic        exp_we = 1'b0;
    logic [16:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    int          exp_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fb_mem_arbiter dut0 (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt[0]),
        .disp_rvalid(disp_rvalid[0]), .disp_rdata(disp_rdata[0]),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata0),
        .clear_stats(clear_stats), .miss_count(miss0)
    );

    fb_mem_arbiter #(.rd_latency(lat1), .w_miss(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt[1]),
        .disp_rvalid(disp_rvalid[1]), .disp_rdata(disp_rdata[1]),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata1),
        .clear_stats(clear_stats), .miss_count(miss1)
    );

    // Unwritten locations read back as their own address.
    function automatic logic [15:0] ram_rd(input int k, input int a);
        if (k == 0) return ram0.exists(a) ? ram0[a] : 16'(a);
        return ram1.exists(a) ? ram1[a] : 16'(a);
    endfunction

    function automatic logic [15:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : 16'(a);
    endfunction

    // RAM models act mid-cycle (write-first) so data is stable at the sampling edge.
    always @(negedge clk) begin
        if (mem_en[0] && mem_we[0]) ram0[int'(mem_addr[0])] = mem_wdata[0];
        mem_rdata0 = ram_rd(0, int'(mem_addr[0]));
    end

    always @(negedge clk) begin
        if (mem_en[1] && mem_we[1]) ram1[int'(mem_addr[1])] = mem_wdata[1];
        mem_rdata1 = stage1[lat1-2];
        for (int i = lat1 - 2; i > 0; i--) stage1[i] = stage1[i-1];
        stage1[0] = ram_rd(1, int'(mem_addr[1]));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q0.size() > 0 && q0[0].due <= cyc) begin
                checkOutput("rvalid0_due", 32'(disp_rvalid[0]), 32'd1);
                checkOutput("rdata0", 32'(disp_rdata[0]), 32'(q0[0].data));
                void'(q0.pop_front());
            end else begin
                checkOutput("rvalid0_idle", 32'(disp_rvalid[0]), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                checkOutput("rvalid1_due", 32'(disp_rvalid[1]), 32'd1);
                checkOutput("rdata1", 32'(disp_rdata[1]), 32'(q1[0].data));
                void'(q1.pop_front());
            end else begin
                checkOutput("rvalid1_idle", 32'(disp_rvalid[1]), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic dreq, input logic [16:0] daddr, input logic wv,
                                 input logic [16:0] waddr, input logic [15:0] wdata,
                                 input logic egnt, input logic erdy, input logic clr);
        logic [15:0] d;
        disp_req    = dreq;
        disp_addr   = daddr;
        wr_valid    = wv;
        wr_addr     = waddr;
        wr_data     = wdata;
        clear_stats = clr;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("disp_gnt%0d", k), 32'(disp_gnt[k]), 32'(egnt));
            checkOutput($sformatf("wr_ready%0d", k), 32'(wr_ready[k]), 32'(erdy));
            checkOutput($sformatf("mem_en%0d", k), 32'(mem_en[k]), 32'(exp_en));
            checkOutput($sformatf("mem_we%0d", k), 32'(mem_we[k]), 32'(exp_we));
            checkOutput($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(exp_addr));
            checkOutput($sformatf("mem_wdata%0d", k), 32'(mem_wdata[k]), 32'(exp_wdata));
        end
        checkOutput("miss0", 32'(miss0), 32'(exp_miss));
        checkOutput("miss1", 32'(miss1), (exp_miss > 15) ? 32'd15 : 32'(exp_miss));
        if (clr) exp_miss = 0;
        else if (dreq && !egnt && exp_miss < 65535) exp_miss++;
        if (egnt) begin
            exp_en   = 1'b1;
            exp_we   = 1'b0;
            exp_addr = daddr;
            d        = shadow_rd(int'(daddr));
            q0.push_back('{cyc + 2, d});
            q1.push_back('{cyc + 1 + lat1, d});
        end else if (wv && erdy) begin
            exp_en    = 1'b1;
            exp_we    = 1'b1;
            exp_addr  = waddr;
            exp_wdata = wdata;
            shadow[int'(waddr)] = wdata;
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic enterReset();
        rst_n       = 1'b0;
        disp_req    = 1'b0;
        wr_valid    = 1'b0;
        clear_stats = 1'b0;
        q0.delete();
        q1.delete();
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_miss = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rst_mem_en%0d", k), 32'(mem_en[k]), 32'd0);
            checkOutput($sformatf("rst_mem_we%0d", k), 32'(mem_we[k]), 32'd0);
            checkOutput($sformatf("rst_mem_addr%0d", k), 32'(mem_addr[k]), 32'd0);
            checkOutput($sformatf("rst_mem_wdata%0d", k), 32'(mem_wdata[k]), 32'd0);
            checkOutput($sformatf("rst_rvalid%0d", k), 32'(disp_rvalid[k]), 32'd0);
            checkOutput($sformatf("rst_rdata%0d", k), 32'(disp_rdata[k]), 32'd0);
        end
        checkOutput("rst_miss0", 32'(miss0), 32'd0);
        checkOutput("rst_miss1", 32'(miss1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wi;
        repeat (2) @(posedge clk);
        #1;
        enterReset();

        // Display only: one grant per cycle, data equals address.
        for (int n = 0; n < 100; n++)
            applyStimulus(1'b1, 17'(n), 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(6);

        // Writer only: eight back-to-back writes.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, '0, 1'b1, 17'(32'h100 + i), 16'(32'hA000 + i), 1'b0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ram0_write", 32'(ram_rd(0, 32'h100 + i)), 32'hA000 + 32'(i));
            checkOutput("ram1_write", 32'(ram_rd(1, 32'h100 + i)), 32'hA000 + 32'(i));
        end

        // Contention: a forced write slot every fifth cycle, reads follow the writes.
        wi = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 17'(32'h1FF + i / 5), 1'b1, 17'(32'h200 + wi), 16'(32'hB000 + wi),
                          (i % 5) != 4, (i % 5) == 4, 1'b0);
            if ((i % 5) == 4) wi++;
        end
        checkOutput("miss0_contention", 32'(miss0), 32'd20);
        checkOutput("miss1_saturated", 32'(miss1), 32'd15);

        // Unused forced slot combined with clear_stats, then an unused slot alone.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                applyStimulus(1'b1, 17'h210, 1'b1, 17'(32'h200 + wi), 16'(32'hB000 + wi),
                              1'b1, 1'b0, 1'b0);
            applyStimulus(1'b1, 17'h210, 1'b0, '0, '0, 1'b0, 1'b1, r == 0);
            checkOutput("miss0_clear", 32'(miss0), 32'(r));
            checkOutput("miss1_clear", 32'(miss1), 32'(r));
        end
        idle(6);

        // Reset one cycle after a grant drops the read.
        applyStimulus(1'b1, 17'h055, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        enterReset();
        idle(4);

        // Write then read of the same address in consecutive slots.
        applyStimulus(1'b0, '0, 1'b1, 17'h300, 16'hCAFE, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 17'h300, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(6);

        checkOutput("q0_drained", 32'(q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
